// File: rtl/div_issue_ctrl.sv
// EXE-stage sequencer for the signed/unsigned AXI-Stream divider IPs: one operand beat per
// DIV/DIVU, EXE held until the result returns, a single HI/LO write, flush-safe draining.
module div_issue_ctrl #(
    parameter int unsigned DIV_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        es_advance,
    input  logic        flush,
    output logic        div_tvalid,
    input  logic        div_tready,
    input  logic        div_dout_valid,
    input  logic [63:0] div_dout,
    output logic        divu_tvalid,
    input  logic        divu_tready,
    input  logic        divu_dout_valid,
    input  logic [63:0] divu_dout,
    output logic [1:0]  hl_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        stall,
    output logic        busy,
    output logic        err
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_TIMEOUT);

    typedef struct packed {
        logic [DATA_W-1:0] quot;
        logic [DATA_W-1:0] rem;
    } div_res_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_ISSUE_F, S_WAIT, S_DONE, S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [1:0]        hl_we_q, hl_we_d;
    logic              div_tvalid_q, div_tvalid_d;
    logic              divu_tvalid_q, divu_tvalid_d;
    logic              busy_q, busy_d;

    logic              div_op_c;
    logic              sel_tready_c;
    logic              sel_dvalid_c;
    div_res_t          sel_res_c;
    logic              in_cnt_q_c, in_cnt_d_c;

    // sel_q steers every handshake to the IP that received the operands
    assign div_op_c     = op_valid & (op_div | op_divu);
    assign sel_tready_c = sel_q ? divu_tready : div_tready;
    assign sel_dvalid_c = sel_q ? divu_dout_valid : div_dout_valid;
    assign sel_res_c    = div_res_t'(sel_q ? divu_dout : div_dout);
    assign in_cnt_q_c   = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign in_cnt_d_c   = (state_d == S_WAIT) || (state_d == S_DRAIN);

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        hl_we_d       = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (div_op_c && !flush) begin
                    state_d = S_ISSUE;
                    sel_d   = op_divu;
                end
            end
            S_ISSUE: begin
                if (sel_tready_c) state_d = flush ? S_DRAIN : S_WAIT;
                else if (flush)   state_d = S_ISSUE_F;
            end
            S_ISSUE_F: begin
                if (sel_tready_c) state_d = S_DRAIN;
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = sel_dvalid_c ? S_IDLE : S_DRAIN;
                end else if (sel_dvalid_c) begin
                    state_d = S_DONE;
                    hi_d    = sel_res_c.rem;
                    lo_d    = sel_res_c.quot;
                    hl_we_d = 2'b11;
                end
            end
            S_DONE: begin
                if (es_advance || flush) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (sel_dvalid_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog restarts on every entry into WAIT/DRAIN and saturates there
        if (in_cnt_d_c && (state_d != state_q)) begin
            cnt_d = '0;
        end else if (in_cnt_q_c && in_cnt_d_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (in_cnt_d_c && (cnt_d == CNT_MAX)) err_d = 1'b1;

        div_tvalid_d  = ((state_d == S_ISSUE) || (state_d == S_ISSUE_F)) && !sel_d;
        divu_tvalid_d = ((state_d == S_ISSUE) || (state_d == S_ISSUE_F)) && sel_d;
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            sel_q         <= 1'b0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            hl_we_q       <= 2'b00;
            div_tvalid_q  <= 1'b0;
            divu_tvalid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            hl_we_q       <= hl_we_d;
            div_tvalid_q  <= div_tvalid_d;
            divu_tvalid_q <= divu_tvalid_d;
            busy_q        <= busy_d;
        end
    end

    // stall must react to the instruction sitting in EXE this cycle
    assign stall       = div_op_c && !flush && (state_q != S_DONE);
    assign div_tvalid  = div_tvalid_q;
    assign divu_tvalid = divu_tvalid_q;
    assign hl_we       = hl_we_q;
    assign hi_wdata    = hi_q;
    assign lo_wdata    = lo_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: a behavioural divider-IP handshake per instruction,
// hand-computed quotient/remainder and cycle counts.
module tb_div_issue_ctrl;
    localparam int RUN_MAX = 400;

    logic        clk;
    logic        resetn;
    logic        op_valid, op_div, op_divu, es_advance, flush;
    logic        div_tvalid, div_tready, div_dout_valid;
    logic [63:0] div_dout;
    logic        divu_tvalid, divu_tready, divu_dout_valid;
    logic [63:0] divu_dout;
    logic [1:0]  hl_we;
    logic [31:0] hi_wdata, lo_wdata;
    logic        stall, busy, err;

    int n_checks = 0;
    int n_errors = 0;

    // Per-run observations
    int          n_tv, n_st, n_we, bad_tv, first_tv, idle_c, adv_c;
    logic [1:0]  we_val;
    logic [31:0] hi_s, lo_s;
    logic        err_mid, err_end;
    logic        fin;

    div_issue_ctrl #(.DIV_TIMEOUT(255)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_div(op_div), .op_divu(op_divu),
        .es_advance(es_advance), .flush(flush),
        .div_tvalid(div_tvalid), .div_tready(div_tready),
        .div_dout_valid(div_dout_valid), .div_dout(div_dout),
        .divu_tvalid(divu_tvalid), .divu_tready(divu_tready),
        .divu_dout_valid(divu_dout_valid), .divu_dout(divu_dout),
        .hl_we(hl_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .stall(stall), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_div_tvalid"},  64'(div_tvalid),  0);
        check({tag, "_divu_tvalid"}, 64'(divu_tvalid), 0);
        check({tag, "_hl_we"},       64'(hl_we),       0);
        check({tag, "_hi"},          64'(hi_wdata),    0);
        check({tag, "_lo"},          64'(lo_wdata),    0);
        check({tag, "_busy"},        64'(busy),        0);
        check({tag, "_err"},         64'(err),         0);
    endtask

    task automatic quiet();
        @(negedge clk);
        op_valid = 0; op_div = 0; op_divu = 0; es_advance = 0; flush = 0;
        div_tready = 0; divu_tready = 0; div_dout_valid = 0; divu_dout_valid = 0;
        div_dout = '0; divu_dout = '0;
    endtask

    // One instruction in EXE; the IP returns res lat cycles after accepting the operands.
    task automatic run_div(input bit u, input int lat, input int tr_lo, input logic [63:0] res,
                           input int flush_at, input int adv_hold);
        bit live;
        bit tv;
        int acc;
        int we_c;
        live = 1; acc = -1; we_c = -1;
        n_tv = 0; n_st = 0; n_we = 0; bad_tv = 0; first_tv = -1; idle_c = -1; adv_c = -1;
        we_val = '0; hi_s = '0; lo_s = '0; err_mid = 0; err_end = 0; fin = 0;
        for (int c = 0; c < RUN_MAX; c++) begin
            @(negedge clk);
            op_valid        = live;
            op_div          = live && !u;
            op_divu         = live && u;
            es_advance      = 0;
            flush           = (c == flush_at);
            div_tready      = !u && (c >= 1 + tr_lo);
            divu_tready     = u && (c >= 1 + tr_lo);
            div_dout_valid  = !u && (acc >= 0) && (c == acc + lat);
            divu_dout_valid = u && (acc >= 0) && (c == acc + lat);
            div_dout        = u ? 64'd0 : res;
            divu_dout       = u ? res : 64'd0;
            #1;
            tv = u ? divu_tvalid : div_tvalid;
            if ((u ? div_tvalid : divu_tvalid) == 1'b1) bad_tv++;
            if (tv) begin
                n_tv++;
                if (first_tv < 0) first_tv = c;
                if (acc < 0 && c >= 1 + tr_lo) acc = c;
            end
            if (stall) n_st++;
            if (hl_we != 2'b00) begin
                n_we++;
                we_val = hl_we;
                hi_s   = hi_wdata;
                lo_s   = lo_wdata;
                if (we_c < 0) we_c = c;
            end
            if (c == 200) err_mid = err;
            err_end = err;
            es_advance = live && !stall && !flush && (we_c >= 0) && (c >= we_c + adv_hold);
            if (flush) live = 0;
            if (es_advance) begin
                adv_c = c; fin = 1;
                break;
            end
            if (!live && !busy) begin
                idle_c = c; fin = 1;
                break;
            end
        end
        check("run_done", 64'(fin), 1);
        check("other_tvalid", 64'(bad_tv), 0);
    endtask

    initial begin
        resetn = 1;
        op_valid = 0; op_div = 0; op_divu = 0; es_advance = 0; flush = 0;
        div_tready = 0; divu_tready = 0; div_dout_valid = 0; divu_dout_valid = 0;
        div_dout = '0; divu_dout = '0;
        #2 resetn = 0;
        #1 check_reset("rst");
        op_valid = 1;
        #1 check("stall_nondiv", 64'(stall), 0);
        op_div = 1; flush = 1;
        #1 check("stall_flush", 64'(stall), 0);
        flush = 0;
        #1 check("stall_div_idle", 64'(stall), 1);
        repeat (2) @(negedge clk);
        op_valid = 0; op_div = 0;
        resetn = 1;

        // DIV 7 / -2: q = -3, r = 1; latency 20 with tready high
        run_div(0, 20, 0, {32'hFFFF_FFFD, 32'h0000_0001}, -1, 0);
        check("t1_first_tv", 64'(first_tv), 1);
        check("t1_n_tvalid", 64'(n_tv), 1);
        check("t1_n_stall", 64'(n_st), 22);
        check("t1_n_we", 64'(n_we), 1);
        check("t1_we_val", 64'(we_val), 64'h3);
        check("t1_hi", 64'(hi_s), 64'h1);
        check("t1_lo", 64'(lo_s), 64'hFFFF_FFFD);

        // DIVU 0xFFFFFFFF / 16 back-to-back, tready low for 3 cycles
        run_div(1, 5, 3, {32'h0FFF_FFFF, 32'h0000_000F}, -1, 0);
        check("t2_first_tv", 64'(first_tv), 1);
        check("t2_n_tvalid", 64'(n_tv), 4);
        check("t2_n_stall", 64'(n_st), 10);
        check("t2_n_we", 64'(n_we), 1);
        check("t2_hi", 64'(hi_s), 64'hF);
        check("t2_lo", 64'(lo_s), 64'h0FFF_FFFF);

        // Flush in WAIT at cycle 5: result drained, HI/LO untouched
        run_div(0, 20, 0, {32'hDEAD_BEEF, 32'h1234_5678}, 5, 0);
        check("t3_n_tvalid", 64'(n_tv), 1);
        check("t3_n_stall", 64'(n_st), 5);
        check("t3_n_we", 64'(n_we), 0);
        check("t3_idle_c", 64'(idle_c), 22);
        check("t3_hi_kept", 64'(hi_wdata), 64'hF);
        check("t3_lo_kept", 64'(lo_wdata), 64'h0FFF_FFFF);

        // Flush while tready low in ISSUE: tvalid held, then drain
        quiet();
        run_div(1, 4, 3, {32'hAAAA_AAAA, 32'h5555_5555}, 2, 0);
        check("t4_n_tvalid", 64'(n_tv), 4);
        check("t4_n_stall", 64'(n_st), 2);
        check("t4_n_we", 64'(n_we), 0);
        check("t4_idle_c", 64'(idle_c), 9);
        check("t4_lo_kept", 64'(lo_wdata), 64'h0FFF_FFFF);

        // DIV -100 / 7: q = -14, r = -2; ms_allowin low 4 cycles in DONE
        quiet();
        run_div(0, 3, 0, {32'hFFFF_FFF2, 32'hFFFF_FFFE}, -1, 4);
        check("t5_n_tvalid", 64'(n_tv), 1);
        check("t5_n_stall", 64'(n_st), 5);
        check("t5_n_we", 64'(n_we), 1);
        check("t5_adv_c", 64'(adv_c), 9);
        check("t5_hi", 64'(hi_s), 64'hFFFF_FFFE);
        check("t5_lo", 64'(lo_s), 64'hFFFF_FFF2);

        // DIVU 10 / 3 immediately after: issues the next cycle
        run_div(1, 2, 0, {32'h0000_0003, 32'h0000_0001}, -1, 0);
        check("t6_first_tv", 64'(first_tv), 1);
        check("t6_n_we", 64'(n_we), 1);
        check("t6_hi", 64'(hi_s), 64'h1);
        check("t6_lo", 64'(lo_s), 64'h3);

        // Result withheld 300 cycles: err rises after 255 cycles in WAIT and sticks
        quiet();
        run_div(0, 300, 0, {32'h0000_0005, 32'h0000_0000}, -1, 0);
        check("t7_err_mid", 64'(err_mid), 0);
        check("t7_err_end", 64'(err_end), 1);
        check("t7_n_we", 64'(n_we), 1);
        repeat (3) quiet();
        #1 check("t7_err_sticky", 64'(err), 1);

        // Asynchronous reset in the middle of an issue
        quiet();
        op_valid = 1; op_div = 1;
        @(negedge clk);
        #1;
        check("t8_tvalid", 64'(div_tvalid), 1);
        check("t8_busy", 64'(busy), 1);
        resetn = 0;
        #1 check_reset("t8_rst");
        @(negedge clk);
        op_valid = 0; op_div = 0;
        resetn = 1;
        @(negedge clk);
        #1 check("t8_idle_after", 64'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
